// File: rtl/memwb_port_arb.sv
// memwb_port_arb: round-robin MEM->WB writeback port arbiter with a
// flush-aware one-entry output register. Optional perf counters: MEMWB_ARB_PERF_EN.
module memwb_port_arb #(
    parameter int NUM_REQ = 2,
    parameter int ROBID_W = 7,
    parameter int PREG_W  = 6,
    parameter int DATA_W  = 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ROBID_W-1:0] req_robid,
    input  logic [NUM_REQ*PREG_W-1:0]  req_prd,
    input  logic [NUM_REQ-1:0]         req_need_to_wb,
    input  logic [NUM_REQ-1:0]         req_mmio,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic                       flush_valid,
    input  logic [ROBID_W-1:0]         flush_robid,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [ROBID_W-1:0]         wb_robid,
    output logic [PREG_W-1:0]          wb_prd,
    output logic                       wb_need_to_wb,
    output logic                       wb_mmio,
    output logic [DATA_W-1:0]          wb_data
`ifdef MEMWB_ARB_PERF_EN
   ,output logic [NUM_REQ*32-1:0]      perf_grant_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   nxt_ptr;
    logic               win_found;
    logic               load_en;
    logic               grant_en;
    logic               squash;
    logic [ROBID_W-1:0] sel_robid;
    logic [PREG_W-1:0]  sel_prd;
    logic               sel_ntw;
    logic               sel_mmio;
    logic [DATA_W-1:0]  sel_data;

    // (a + b) mod NUM_REQ for a < NUM_REQ, b <= NUM_REQ
    function automatic logic [PTR_W-1:0] wrap_add(
        input logic [PTR_W-1:0] a,
        input logic [PTR_W:0]   b
    );
        logic [PTR_W:0] s;
        s = {1'b0, a} + b;
        if (s >= (PTR_W+1)'(NUM_REQ))
            s = s - (PTR_W+1)'(NUM_REQ);
        return s[PTR_W-1:0];
    endfunction

    // a is younger than b under the wrap-bit ROB id ordering
    function automatic logic is_younger(
        input logic [ROBID_W-1:0] a,
        input logic [ROBID_W-1:0] b
    );
        if (a[ROBID_W-1] == b[ROBID_W-1])
            return a[ROBID_W-2:0] > b[ROBID_W-2:0];
        else
            return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    endfunction

    assign load_en  = !wb_valid || wb_ready;
    assign grant_en = reset_n && win_found && load_en && !flush_valid;
    assign squash   = flush_valid && wb_valid && is_younger(wb_robid, flush_robid);
    assign nxt_ptr  = wrap_add(win_idx, (PTR_W+1)'(1));

    // first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        logic [PTR_W-1:0] c;
        win_found = 1'b0;
        win_idx   = '0;
        c         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = wrap_add(rr_ptr, (PTR_W+1)'(k));
            if (!win_found && req_valid[c]) begin
                win_found = 1'b1;
                win_idx   = c;
            end
        end
    end

    // one-hot accept and payload select for the winner
    always_comb begin
        req_ready = '0;
        sel_robid = '0;
        sel_prd   = '0;
        sel_ntw   = 1'b0;
        sel_mmio  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                req_ready[i] = grant_en;
                sel_robid    = req_robid[i*ROBID_W +: ROBID_W];
                sel_prd      = req_prd[i*PREG_W +: PREG_W];
                sel_ntw      = req_need_to_wb[i];
                sel_mmio     = req_mmio[i];
                sel_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // round-robin pointer moves past the winner on each grant
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (grant_en)
            rr_ptr <= nxt_ptr;
    end

    // output stage: fill on grant, empty on drain or younger-than-flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid      <= 1'b0;
            wb_robid      <= '0;
            wb_prd        <= '0;
            wb_need_to_wb <= 1'b0;
            wb_mmio       <= 1'b0;
            wb_data       <= '0;
        end else if (grant_en) begin
            wb_valid      <= 1'b1;
            wb_robid      <= sel_robid;
            wb_prd        <= sel_prd;
            wb_need_to_wb <= sel_ntw;
            wb_mmio       <= sel_mmio;
            wb_data       <= sel_data;
        end else if (wb_ready || squash) begin
            wb_valid      <= 1'b0;
        end
    end

`ifdef MEMWB_ARB_PERF_EN
    // per-requester grant counts and stalled-request cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i])
                    perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
            if (|req_valid && !grant_en)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

    a_onehot: assert property (
        @(posedge clock) disable iff (!reset_n) $onehot0(req_ready));

    a_wb_hold: assert property (
        @(posedge clock) disable iff (!reset_n)
        (wb_valid && !wb_ready && !flush_valid) |=>
        (wb_valid && $stable(wb_robid) && $stable(wb_data)));

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
        a_req_hold: assert property (
            @(posedge clock) disable iff (!reset_n)
            (req_valid[g] && !req_ready[g]) |=>
            (!req_valid[g] ||
             ($stable(req_robid[g*ROBID_W +: ROBID_W]) &&
              $stable(req_prd[g*PREG_W +: PREG_W]) &&
              $stable(req_need_to_wb[g]) &&
              $stable(req_mmio[g]) &&
              $stable(req_data[g*DATA_W +: DATA_W]))));
    end

endmodule

// File: tb/tb_memwb_port_arb.sv
// tb_memwb_port_arb: directed plan scenarios plus random traffic
// checked against a cycle model of the writeback port arbiter.
module tb_memwb_port_arb;

    localparam int N  = 2;
    localparam int RW = 7;
    localparam int PW = 6;
    localparam int DW = 64;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*RW-1:0]   req_robid;
    logic [N*PW-1:0]   req_prd;
    logic [N-1:0]      req_need_to_wb;
    logic [N-1:0]      req_mmio;
    logic [N*DW-1:0]   req_data;
    logic              flush_valid;
    logic [RW-1:0]     flush_robid;
    logic              wb_valid;
    logic              wb_ready;
    logic [RW-1:0]     wb_robid;
    logic [PW-1:0]     wb_prd;
    logic              wb_need_to_wb;
    logic              wb_mmio;
    logic [DW-1:0]     wb_data;
`ifdef MEMWB_ARB_PERF_EN
    logic [N*32-1:0]   perf_grant_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    memwb_port_arb #(.NUM_REQ(N), .ROBID_W(RW), .PREG_W(PW), .DATA_W(DW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_robid      (req_robid),
        .req_prd        (req_prd),
        .req_need_to_wb (req_need_to_wb),
        .req_mmio       (req_mmio),
        .req_data       (req_data),
        .flush_valid    (flush_valid),
        .flush_robid    (flush_robid),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_robid       (wb_robid),
        .wb_prd         (wb_prd),
        .wb_need_to_wb  (wb_need_to_wb),
        .wb_mmio        (wb_mmio),
        .wb_data        (wb_data)
`ifdef MEMWB_ARB_PERF_EN
       ,.perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // requester-side pending entries
    logic          src_v[N];
    logic [RW-1:0] src_robid[N];
    logic [PW-1:0] src_prd[N];
    logic          src_ntw[N];
    logic          src_mmio[N];
    logic [DW-1:0] src_data[N];

    logic          n_wb_ready;
    logic          n_flush_valid;
    logic [RW-1:0] n_flush_robid;

    // reference model of the output entry
    logic          m_valid;
    logic [RW-1:0] m_robid;
    logic [PW-1:0] m_prd;
    logic          m_ntw;
    logic          m_mmio;
    logic [DW-1:0] m_data;
    int            m_ptr;
    logic [31:0]   m_gcnt[N];
    logic [31:0]   m_stall;

    logic [N-1:0]  obs_ready;
    logic          obs_valid;
    logic [RW-1:0] obs_robid;
    logic [DW-1:0] obs_data;

    logic [N-1:0]  g_seq[4];
    logic [RW-1:0] r_seq[4];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // younger means a lies 1..half-range ahead of b on the ROB id circle
    function automatic bit younger(input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic [RW-1:0] d;
        d = a - b;
        return (d != 0) && (d < RW'(1 << (RW - 1)));
    endfunction

    task automatic put(input int i, input logic [RW-1:0] id, input logic [DW-1:0] d);
        src_v[i]     = 1'b1;
        src_robid[i] = id;
        src_prd[i]   = PW'($urandom);
        src_ntw[i]   = 1'($urandom);
        src_mmio[i]  = 1'($urandom);
        src_data[i]  = d;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_stall = '0;
        for (int i = 0; i < N; i++) begin
            m_gcnt[i] = '0;
            src_v[i]  = 1'b0;
        end
    endtask

    task automatic zero_inputs();
        req_valid      = '0;
        req_robid      = '0;
        req_prd        = '0;
        req_need_to_wb = '0;
        req_mmio       = '0;
        req_data       = '0;
        flush_valid    = 1'b0;
        flush_robid    = '0;
        wb_ready       = 1'b0;
    endtask

    task automatic check_perf();
`ifdef MEMWB_ARB_PERF_EN
        for (int i = 0; i < N; i++)
            chk("perf_grant", 64'(perf_grant_cnt[i*32 +: 32]), 64'(m_gcnt[i]));
        chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
`endif
    endtask

    // one clock: drive at negedge, check, then advance the model at posedge
    task automatic step();
        int eg;
        logic [N-1:0] em;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = src_v[i];
            req_robid[i*RW +: RW]  = src_robid[i];
            req_prd[i*PW +: PW]    = src_prd[i];
            req_need_to_wb[i]      = src_ntw[i];
            req_mmio[i]            = src_mmio[i];
            req_data[i*DW +: DW]   = src_data[i];
        end
        wb_ready    = n_wb_ready;
        flush_valid = n_flush_valid;
        flush_robid = n_flush_robid;
        #1;
        eg = -1;
        if ((!m_valid || wb_ready) && !flush_valid) begin
            for (int k = 0; k < N; k++) begin
                if (eg < 0 && req_valid[(m_ptr + k) % N])
                    eg = (m_ptr + k) % N;
            end
        end
        em = '0;
        if (eg >= 0) em[eg] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(em));
        chk("wb_valid", 64'(wb_valid), 64'(m_valid));
        if (m_valid) begin
            chk("wb_robid", 64'(wb_robid), 64'(m_robid));
            chk("wb_prd", 64'(wb_prd), 64'(m_prd));
            chk("wb_ntw", 64'(wb_need_to_wb), 64'(m_ntw));
            chk("wb_mmio", 64'(wb_mmio), 64'(m_mmio));
            chk("wb_data", wb_data, m_data);
        end
        check_perf();
        obs_ready = req_ready;
        obs_valid = wb_valid;
        obs_robid = wb_robid;
        obs_data  = wb_data;
        @(posedge clock);
        if (|req_valid && eg < 0) m_stall++;
        if (eg >= 0) begin
            m_valid    = 1'b1;
            m_robid    = src_robid[eg];
            m_prd      = src_prd[eg];
            m_ntw      = src_ntw[eg];
            m_mmio     = src_mmio[eg];
            m_data     = src_data[eg];
            m_ptr      = (eg + 1) % N;
            m_gcnt[eg] = m_gcnt[eg] + 1;
            src_v[eg]  = 1'b0;
        end else if (wb_ready || (flush_valid && younger(m_robid, flush_robid))) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drain();
        n_wb_ready    = 1'b1;
        n_flush_valid = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        reset_n = 1'b0;
        zero_inputs();
        model_reset();
        n_wb_ready    = 1'b0;
        n_flush_valid = 1'b0;
        n_flush_robid = '0;
        for (int i = 0; i < N; i++) begin
            src_robid[i] = '0;
            src_prd[i]   = '0;
            src_ntw[i]   = 1'b0;
            src_mmio[i]  = 1'b0;
            src_data[i]  = '0;
        end

        // reset state
        #1 req_valid = '1;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_valid", 64'(wb_valid), 64'h0);
        chk("rst_robid", 64'(wb_robid), 64'h0);
        chk("rst_prd", 64'(wb_prd), 64'h0);
        chk("rst_data", wb_data, 64'h0);
        check_perf();
        req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;

        // contention: both requesters valid for four grants
        n_wb_ready = 1'b1;
        put(0, 7'h10, 64'h100);
        put(1, 7'h11, 64'h101);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) put(0, 7'h12, 64'h102);
            if (c == 2) put(1, 7'h13, 64'h103);
            step();
            if (c < 4) g_seq[c] = obs_ready;
            if (c > 0) r_seq[c-1] = obs_robid;
        end
        chk("cont_g0", 64'(g_seq[0]), 64'h1);
        chk("cont_g1", 64'(g_seq[1]), 64'h2);
        chk("cont_g2", 64'(g_seq[2]), 64'h1);
        chk("cont_g3", 64'(g_seq[3]), 64'h2);
        for (int c = 0; c < 4; c++)
            chk("cont_robid", 64'(r_seq[c]), 64'(7'h10 + c));
        put(0, 7'h14, 64'h104);
        put(1, 7'h15, 64'h105);
        step();
        chk("cont_ptr0", 64'(obs_ready), 64'h1);
        drain();

        // backpressure
        put(0, 7'h05, 64'h5);
        step();
        put(1, 7'h06, 64'h6);
        n_wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_robid", 64'(obs_robid), 64'h05);
            chk("bp_ready", 64'(obs_ready), 64'h0);
        end
        n_wb_ready = 1'b1;
        step();
        chk("bp_grant", 64'(obs_ready), 64'h2);
        step();
        chk("bp_next_v", 64'(obs_valid), 64'h1);
        chk("bp_next_id", 64'(obs_robid), 64'h06);
        drain();

        // flush younger squashes the held entry
        put(0, 7'h45, 64'h45);
        step();
        n_wb_ready    = 1'b0;
        n_flush_valid = 1'b1;
        n_flush_robid = 7'h42;
        step();
        n_flush_valid = 1'b0;
        step();
        chk("fl_young", 64'(obs_valid), 64'h0);

        // flush older keeps the held entry
        put(0, 7'h45, 64'h46);
        step();
        n_flush_valid = 1'b1;
        n_flush_robid = 7'h47;
        step();
        n_flush_valid = 1'b0;
        step();
        chk("fl_old_v", 64'(obs_valid), 64'h1);
        chk("fl_old_id", 64'(obs_robid), 64'h45);
        drain();

        // flush across the wrap bit
        put(0, 7'h01, 64'h1);
        step();
        n_wb_ready    = 1'b0;
        n_flush_valid = 1'b1;
        n_flush_robid = 7'h7E;
        step();
        n_flush_valid = 1'b0;
        step();
        chk("fl_wrap", 64'(obs_valid), 64'h0);
        drain();

        // single source streaming, one per cycle
        n_wb_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) put(1, RW'(7'h20 + k), 64'hA5A5_0000_0000_0000 + 64'(k));
            step();
            if (k > 0) begin
                chk("str_valid", 64'(obs_valid), 64'h1);
                chk("str_data", obs_data, 64'hA5A5_0000_0000_0000 + 64'(k - 1));
            end
        end
        drain();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!src_v[i] && ($urandom % 3 != 0))
                    put(i, RW'($urandom), {$urandom, $urandom});
            n_wb_ready    = ($urandom % 4) != 0;
            n_flush_valid = ($urandom % 8) == 0;
            n_flush_robid = RW'($urandom);
            step();
        end
        drain();

        // reset mid-transfer
        n_wb_ready = 1'b0;
        put(0, 7'h30, 64'h30);
        step();
        #2;
        chk("mid_pre_v", 64'(wb_valid), 64'h1);
        reset_n = 1'b0;
        zero_inputs();
        #1;
        chk("mid_rst_v", 64'(wb_valid), 64'h0);
        chk("mid_rst_rdy", 64'(req_ready), 64'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_perf();
        n_wb_ready = 1'b1;
        put(0, 7'h31, 64'h31);
        put(1, 7'h32, 64'h32);
        step();
        chk("mid_first", 64'(obs_ready), 64'h1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memwb_port_arb.md
Name: memwb_port_arb

Overview:
- Shares the single MEM->WB writeback port among NUM_REQ load-result sources, e.g. the load pipe and the MMIO/uncached completion path.
- Round-robin arbiter with a one-entry registered output stage and valid/ready handshakes on both sides.
- Flush-aware: on a redirect it squashes a held result younger than the redirecting instruction.
- Sits between the memblock load sources and the MEM/WB pipeline register, replacing its direct feed.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ROBID_W, 7, ROB id width; MSB is the wrap bit, the remaining bits are the index.
- PREG_W, 6, physical destination register width.
- DATA_W, 64, load result width.

Ports:
- clock  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester result valid.
- req_ready  out  NUM_REQ  per-requester accept; high only for the granted requester.
- req_robid  in  NUM_REQ*ROBID_W  flattened ROB ids; requester i occupies bits [i*ROBID_W +: ROBID_W].
- req_prd  in  NUM_REQ*PREG_W  flattened destination pregs.
- req_need_to_wb  in  NUM_REQ  regfile write required.
- req_mmio  in  NUM_REQ  result originates from MMIO.
- req_data  in  NUM_REQ*DATA_W  flattened load data.
- flush_valid  in  1  redirect this cycle.
- flush_robid  in  ROBID_W  ROB id of the redirecting instruction.
- wb_valid  out  1  output entry valid.
- wb_ready  in  1  downstream accepts the output entry.
- wb_robid  out  ROBID_W  output field.
- wb_prd  out  PREG_W  output field.
- wb_need_to_wb  out  1  output field.
- wb_mmio  out  1  output field.
- wb_data  out  DATA_W  output field.

Behaviour:
- Reset (async assert, sync deassert by the surrounding logic):
  - wb_valid=0; all wb_* fields=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while in reset.
- Load condition: load_en = !wb_valid || wb_ready. The output stage accepts a new entry only when load_en=1.
- Grant, combinational:
  - Candidate set is the requesters with req_valid=1.
  - Search starts at rr_ptr and increments modulo NUM_REQ; the first candidate found wins.
  - The winner is granted only if load_en=1 and flush_valid=0.
  - req_ready[i] = grant[i]; at most one bit is ever set.
  - A requester's transfer completes on a cycle where req_valid[i] && req_ready[i].
- Latency: a grant in cycle T makes wb_valid=1 with the winner's fields in cycle T+1. There is one register stage and no combinational path from req_* to wb_*.
- Backpressure: while wb_valid && !wb_ready, all wb_* outputs hold stable and no grant is issued.
- Simultaneous drain and fill: when wb_valid && wb_ready and a grant occurs, the register is overwritten with the new entry (full throughput, one result per cycle).
- Drain with no grant: when wb_valid && wb_ready and there is no grant, wb_valid goes to 0 next cycle. The data fields may retain stale values.
- rr_ptr update: on a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ grant opportunities.
- Age compare: a is younger than b iff
  - wrap bits equal: a.idx > b.idx;
  - wrap bits differ: a.idx < b.idx.
  - Equal robid counts as not younger.
- Flush cycle (flush_valid=1):
  - No grant; req_ready=0.
  - If wb_valid and wb_robid is younger than flush_robid, wb_valid <= 0 next cycle, even if wb_ready=1.
  - An entry equal to or older than flush_robid follows the normal handshake.
  - rr_ptr holds.
  - Requesters squash their own younger entries; the arbiter does not check pending requests.
- Single requester: the arbiter passes entries through at one per cycle with no bubbles.
- Reset mid-operation: any held entry is dropped immediately (wb_valid=0 asynchronously).
- Protocol assumptions, enforced by assertion in simulation:
  - a requester must hold its req_* fields stable while req_valid && !req_ready;
  - downstream must not depend on wb fields when wb_valid=0.

Optional Feature:
- Macro: MEMWB_ARB_PERF_EN.
- When defined, the block adds
  - perf_grant_cnt (out, NUM_REQ*32): per-requester grant counters;
  - perf_stall_cnt (out, 32): counts cycles with at least one req_valid=1 and no grant.
- All counters reset to 0 and wrap modulo 2^32.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Contention: reset, then req_valid=2'b11 for 4 cycles, wb_ready=1.
  - Required: grants 0,1,0,1.
  - Required: wb_robid sequence equals the requesters' ids, one per cycle, starting the cycle after the first grant.
  - Required: rr_ptr ends at 0.
- Backpressure: hold wb_ready=0 for 3 cycles with wb_valid=1 and robid=0x05.
  - Required: wb_* stable at 0x05.
  - Required: req_ready=0.
  - Required: on wb_ready=1, the next entry appears the following cycle.
- Flush younger: hold wb_robid=0x45 and raise flush_valid with flush_robid=0x42.
  - Required: wb_valid=0 next cycle.
- Flush older, and flush across the wrap bit: repeat with flush_robid=0x47.
  - Required: entry 0x45 is kept.
  - Wrap case: wb_robid=0x01 with flush_robid=0x7E is younger and is squashed.
- Single source streaming: req_valid[1]=1 for 8 cycles with distinct data, wb_ready=1.
  - Required: 8 consecutive wb_valid cycles with data in order and no bubbles.
- Reset mid-transfer: assert reset_n=0 while wb_valid=1.
  - Required: wb_valid=0 immediately.
  - Required: after release, the first grant goes to requester 0; perf counters (if enabled) are 0.
